// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module  : core_pkg
// Brief   : Shared widths, ALU encodings and instruction field layout.
// Revision: 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int DATA_W = 32;
    localparam int NREG   = 16;
    localparam int REG_AW = 4;
    localparam int IMM_W  = 16;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;
    localparam logic [1:0] ALU_NAND = 2'b11;

    localparam int OP_HI       = 31;
    localparam int OP_LO       = 30;
    localparam int IMM_SEL_BIT = 29;
    localparam int WB_REQ_BIT  = 28;
    localparam int RD_HI       = 27;
    localparam int RD_LO       = 24;
    localparam int RS1_HI      = 23;
    localparam int RS1_LO      = 20;
    localparam int RS2_HI      = 19;
    localparam int RS2_LO      = 16;
    localparam int IMM_HI      = 15;
    localparam int IMM_LO      = 0;

    typedef struct packed {
        logic [1:0]        alu_op;
        logic              imm_sel;
        logic              wb_req;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [DATA_W-1:0] imm_ext;
    } decoded_t;

    function automatic decoded_t decode(input logic [31:0] instr);
        decoded_t d;
        d.alu_op  = instr[OP_HI:OP_LO];
        d.imm_sel = instr[IMM_SEL_BIT];
        d.wb_req  = instr[WB_REQ_BIT];
        d.rd      = instr[RD_HI:RD_LO];
        d.rs1     = instr[RS1_HI:RS1_LO];
        d.rs2     = instr[RS2_HI:RS2_LO];
        d.imm_ext = {{(DATA_W-IMM_W){instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module  : reg_file
// Brief   : 2R/1W register file, r0 hardwired to zero, write-to-read bypass.
// Revision: 1.0 - initial release
// ============================================================================
module reg_file
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] r_mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Same-cycle writeback is forwarded so the consumer need not wait a cycle.
    always_comb begin
        rd_data_a = r_mem[rd_addr_a];
        if (rd_addr_a == '0) begin
            rd_data_a = '0;
        end else if (wr_en && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
    end

    always_comb begin
        rd_data_b = r_mem[rd_addr_b];
        if (rd_addr_b == '0) begin
            rd_data_b = '0;
        end else if (wr_en && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/issue_stage.sv
`default_nettype none
// ============================================================================
// Module  : issue_stage
// Brief   : Decode, scoreboard hazard check and registered ALU issue bundle.
// Revision: 1.0 - initial release
// ============================================================================
module issue_stage
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [1:0]        out_alu_op,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wb_req,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    localparam logic [NREG-1:0] c_one = {{(NREG-1){1'b0}}, 1'b1};

    decoded_t          w_dec;
    logic [DATA_W-1:0] w_rs1_data;
    logic [DATA_W-1:0] w_rs2_data;
    logic [NREG-1:0]   w_clr;
    logic [NREG-1:0]   w_pend_eff;
    logic              w_hazard;
    logic              w_accept;

    logic [NREG-1:0]   r_pend;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_a;
    logic [DATA_W-1:0] r_out_b;
    logic [1:0]        r_out_alu_op;
    logic [REG_AW-1:0] r_out_rd;
    logic              r_out_wb_req;

    assign w_dec = decode(in_instr);

    reg_file u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (w_dec.rs1),
        .rd_addr_b (w_dec.rs2),
        .rd_data_a (w_rs1_data),
        .rd_data_b (w_rs2_data),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data)
    );

    // A register being written back this cycle is already resolved by the bypass.
    assign w_clr      = wb_en ? (c_one << wb_addr) : '0;
    assign w_pend_eff = r_pend & ~w_clr;

    always_comb begin
        w_hazard = 1'b0;
        if ((w_dec.rs1 != '0) && w_pend_eff[w_dec.rs1]) begin
            w_hazard = 1'b1;
        end
        if (!w_dec.imm_sel && (w_dec.rs2 != '0) && w_pend_eff[w_dec.rs2]) begin
            w_hazard = 1'b1;
        end
        if (w_dec.wb_req && (w_dec.rd != '0) && w_pend_eff[w_dec.rd]) begin
            w_hazard = 1'b1;
        end
    end

    assign in_ready = !rst && !w_hazard && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            // Set is applied after clear so a same-register collision keeps the bit.
            r_pend <= (r_pend & ~w_clr)
                    | ((w_accept && w_dec.wb_req && (w_dec.rd != '0)) ? (c_one << w_dec.rd) : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_a      <= '0;
            r_out_b      <= '0;
            r_out_alu_op <= ALU_ADD;
            r_out_rd     <= '0;
            r_out_wb_req <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_a      <= w_rs1_data;
            r_out_b      <= w_dec.imm_sel ? w_dec.imm_ext : w_rs2_data;
            r_out_alu_op <= w_dec.alu_op;
            r_out_rd     <= w_dec.rd;
            r_out_wb_req <= w_dec.wb_req;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_a      = r_out_a;
    assign out_b      = r_out_b;
    assign out_alu_op = r_out_alu_op;
    assign out_rd     = r_out_rd;
    assign out_wb_req = r_out_wb_req;

endmodule
`default_nettype wire
